alu_shift_unit: RTL

Result shifter stage directly downstream of the 16-bit ALU. It latches the ALU result bus `F` and the ALU `flag` word on a load strobe. On `start` it then performs a multi-cycle shift, one bit per clock, under a simple start/busy/done handshake. The shifted result and the updated carry/zero/negative flags are held for the bus and the sequencer.

---
 rtl/alu_shift_pkg.sv | 41 ++++
 rtl/alu_shift_step.sv | 64 ++++++
 rtl/alu_shift_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the ALU result shifter stage.
//   shift_op_t    : 3-bit operation code for one shift step
//   shift_state_t : IDLE / SHIFT / DONE sequencer states
//   FLAG_C/Z/N    : bit positions of carry, zero and negative in the flag word
//   update_flags  : rewrites C/Z/N in a flag word, keeping every other bit
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_SAR  = 3'b011,
    OP_RCL  = 3'b100,
    OP_RCR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  function automatic logic [15:0] update_flags(input logic [15:0] flags,
                                               input logic        c,
                                               input logic        z,
                                               input logic        n);
    logic [15:0] r;
    r         = flags;
    r[FLAG_C] = c;
    r[FLAG_Z] = z;
    r[FLAG_N] = n;
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift step.
// Configuration macro: ALU_SHIFT_ROTATE_EN enables the rotate ops
// (RCL/RCR/ROL/ROR); without it those codes leave q and co untouched.
// Ports:
//   op      in  shift_op_t : operation to apply
//   q       in  WIDTH      : current register contents
//   co      in  1          : current carry
//   q_next  out WIDTH      : contents after one step
//   co_next out 1          : carry after one step
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  shift_op_t        op,
  input  logic [WIDTH-1:0] q,
  input  logic             co,
  output logic [WIDTH-1:0] q_next,
  output logic             co_next
);

  always_comb begin
    q_next  = q;
    co_next = co;
    case (op)
      OP_SHL: begin
        co_next = q[WIDTH-1];
        q_next  = {q[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        co_next = q[0];
        q_next  = {1'b0, q[WIDTH-1:1]};
      end
      OP_SAR: begin
        co_next = q[0];
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
      end
`ifdef ALU_SHIFT_ROTATE_EN
      // Rotate through carry: a WIDTH+1 bit ring made of {co, q}.
      OP_RCL: begin
        co_next = q[WIDTH-1];
        q_next  = {q[WIDTH-2:0], co};
      end
      OP_RCR: begin
        co_next = q[0];
        q_next  = {co, q[WIDTH-1:1]};
      end
      OP_ROL: begin
        co_next = q[WIDTH-1];
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
      end
      OP_ROR: begin
        co_next = q[0];
        q_next  = {q[0], q[WIDTH-1:1]};
      end
`endif
      default: begin
        q_next  = q;
        co_next = co;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Result shifter stage behind the 16-bit ALU. Latches the ALU result and
// flag word on LDSR, then on start shifts one bit per clock for amt cycles
// and rewrites C/Z/N from the final result.
// Configuration macro: ALU_SHIFT_ROTATE_EN (rotate ops; see alu_shift_step).
// Handshake: start is sampled only in IDLE; busy is high while shifting;
// done pulses for exactly one cycle when the result and flags are final.
// start/LDSR/op/amt are ignored while busy or done; nothing is queued.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   F         : ALU result bus          flag_in  : ALU flag word
//   LDSR      : load strobe (wins over start)
//   start/op/amt : operation request
//   Q, CO     : shift register and carry
//   flag_out  : latched flags with C/Z/N updated
//   busy/done : status; state : sequencer state for observation
module alu_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] F,
  input  logic [15:0]      flag_in,
  input  logic             LDSR,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic [15:0]      flag_out,
  output logic             busy,
  output logic             done,
  output shift_state_t     state
);

  shift_state_t     state_next;
  shift_op_t        op_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_q;
  logic             step_co;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .q       (Q),
    .co      (CO),
    .q_next  (step_q),
    .co_next (step_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!LDSR && start) state_next = (amt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        // The last step and the move to DONE share one edge.
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q        <= '0;
      CO       <= 1'b0;
      flag_out <= '0;
      cnt      <= '0;
      op_r     <= OP_PASS;
    end else begin
      case (state)
        IDLE: begin
          if (LDSR) begin
            Q        <= F;
            flag_out <= flag_in;
            CO       <= flag_in[FLAG_C];
          end else if (start) begin
            if (amt != '0) begin
              op_r <= shift_op_t'(op);
              cnt  <= amt;
            end else begin
              // Zero-length operation: Q/CO stay, flags still recomputed.
              flag_out <= update_flags(flag_out, CO, Q == '0, Q[WIDTH-1]);
            end
          end
        end
        SHIFT: begin
          Q   <= step_q;
          CO  <= step_co;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            flag_out <= update_flags(flag_out, step_co, step_q == '0,
                                     step_q[WIDTH-1]);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
